// File: rtl/rgb_mixer_pkg.sv
// Shared constants, reporter state type and frame byte helper for the
// encoder-level UART reporter.
package rgb_mixer_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 5;
   localparam int         UART_BITS   = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } rep_state_t;

   // Byte idx of a frame: SYNC, L0, L1, L2, then the XOR checksum.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input logic [7:0] l0,
                                             input logic [7:0] l1,
                                             input logic [7:0] l2);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = l0;
         3'd2:    b = l1;
         3'd3:    b = l2;
         default: b = l0 ^ l1 ^ l2;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/enc_uart_reporter_tx_byte.sv
// 8N1 UART byte transmitter. A byte is loaded on start; done pulses in the
// last cycle of the stop bit, and a start in that same cycle chains the next
// byte with no idle time in between.
module uart_tx_byte
   import rgb_mixer_pkg::*;
#(
   parameter int CLK_DIV = 87
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int             BW        = $clog2(CLK_DIV);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [3:0]     BIT_LAST  = 4'(UART_BITS - 1);

   logic          active_reg;
   logic [BW-1:0] baud_cnt_reg;
   logic [3:0]    bit_idx_reg;
   logic [8:0]    shift_reg;   // {stop, data[7:0]}; bit 0 is the next bit out
   logic          tx_reg;
   logic          bit_end;
   logic          load;

   assign bit_end = active_reg && (baud_cnt_reg == BAUD_LAST);
   assign done    = bit_end && (bit_idx_reg == BIT_LAST);
   assign load    = start && (!active_reg || done);
   assign tx      = tx_reg;

   // Baud counter, bit index and shift register; tx is driven from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_reg   <= 1'b0;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else if (load) begin
         active_reg   <= 1'b1;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= {1'b1, data};
         tx_reg       <= 1'b0;
      end else if (active_reg) begin
         if (bit_end) begin
            baud_cnt_reg <= '0;
            if (done) begin
               active_reg  <= 1'b0;
               bit_idx_reg <= '0;
               tx_reg      <= 1'b1;
            end else begin
               bit_idx_reg <= bit_idx_reg + 4'd1;
               tx_reg      <= shift_reg[0];
               shift_reg   <= {1'b1, shift_reg[8:1]};
            end
         end else begin
            baud_cnt_reg <= baud_cnt_reg + BW'(1);
         end
      end
   end

endmodule

// File: rtl/enc_uart_reporter.sv
// Watches the three encoder levels and, whenever they differ from the last
// reported snapshot, sends SYNC/L0/L1/L2/CHK over an 8N1 UART line followed
// by a forced idle gap.
module enc_uart_reporter
   import rgb_mixer_pkg::*;
#(
   parameter int CLK_DIV  = 87,
   parameter int GAP_BITS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] level0,
   input  logic [7:0] level1,
   input  logic [7:0] level2,
   output logic       tx,
   output logic       busy
);

   localparam int            GAP_CYC   = GAP_BITS * CLK_DIV;
   localparam int            GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [2:0]    BYTE_LAST = 3'(FRAME_BYTES - 1);

   rep_state_t    state_reg;
   rep_state_t    state_next;
   logic [23:0]   snapshot_reg;
   logic          init_pending_reg;
   logic [2:0]    byte_idx_reg;
   logic [GW-1:0] gap_cnt_reg;

   logic          changed;
   logic          gap_end;
   logic          last_byte;
   logic          start;
   logic [7:0]    byte_data;
   logic          byte_done;

   assign changed   = init_pending_reg || ({level0, level1, level2} != snapshot_reg);
   assign gap_end   = (gap_cnt_reg == GAP_LAST);
   assign last_byte = (byte_idx_reg == BYTE_LAST);

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .data  (byte_data),
      .tx    (tx),
      .done  (byte_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: levels are only looked at while idle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (changed) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (byte_done && last_byte) begin
               state_next = (GAP_BITS == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_end) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: byte start strobe, byte mux (next byte of the frame) and busy.
   always_comb begin
      start     = 1'b0;
      byte_data = SYNC_BYTE;
      busy      = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            start = changed;
         end
         SEND: begin
            if (byte_done && !last_byte) begin
               start     = 1'b1;
               byte_data = frame_byte(byte_idx_reg + 3'd1, snapshot_reg[23:16],
                                      snapshot_reg[15:8], snapshot_reg[7:0]);
            end
         end
         default: ;
      endcase
   end

   // Snapshot is captured only on the edge that launches a frame, so it stays
   // frozen for the whole frame and gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         snapshot_reg     <= '0;
         init_pending_reg <= 1'b1;
      end else if (state_reg == IDLE && changed) begin
         snapshot_reg     <= {level0, level1, level2};
         init_pending_reg <= 1'b0;
      end
   end

   // Byte index within the frame.
   always_ff @(posedge clk) begin
      if (reset || state_reg == IDLE) begin
         byte_idx_reg <= '0;
      end else if (state_reg == SEND && byte_done && !last_byte) begin
         byte_idx_reg <= byte_idx_reg + 3'd1;
      end
   end

   // Post-frame gap counter, running only in GAP.
   always_ff @(posedge clk) begin
      if (reset || state_reg != GAP) begin
         gap_cnt_reg <= '0;
      end else begin
         gap_cnt_reg <= gap_cnt_reg + GW'(1);
      end
   end

endmodule

// File: tb/tb_enc_uart_reporter.sv
// Directed bench for enc_uart_reporter with CLK_DIV=4, GAP_BITS=2.
module tb_enc_uart_reporter;

   localparam int CLK_DIV   = 4;
   localparam int GAP_BITS  = 2;
   localparam int FRAME_CYC = 50 * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] level0 = 8'h00;
   logic [7:0] level1 = 8'h00;
   logic [7:0] level2 = 8'h00;
   logic       tx;
   logic       busy;

   int checks = 0;
   int failures = 0;

   int frames_started = 0;
   int busy_run = 0;
   int last_busy_len = 0;
   logic busy_prev = 1'b0;

   enc_uart_reporter #(
      .CLK_DIV  (CLK_DIV),
      .GAP_BITS (GAP_BITS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .level0 (level0),
      .level1 (level1),
      .level2 (level2),
      .tx     (tx),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Busy-pulse length and frame-start counter.
   always @(negedge clk) begin
      busy_prev <= (busy === 1'b1);
      if (busy === 1'b1 && !busy_prev) frames_started <= frames_started + 1;
      busy_run <= (busy === 1'b1) ? busy_run + 1 : 0;
      if (busy !== 1'b1 && busy_run != 0) last_busy_len <= busy_run;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Waits up to budget negedges for a start bit, then samples one whole
   // frame per cycle and decodes it at bit centres.
   task automatic recv_frame(input int budget, output logic [39:0] frame,
                             output logic framing_ok, output logic timing_ok,
                             output int waited);
      logic s [0:FRAME_CYC-1];
      frame = '0;
      framing_ok = 1'b0;
      timing_ok = 1'b0;
      waited = 0;
      @(negedge clk);
      while (tx !== 1'b0 && waited < budget) begin
         waited++;
         @(negedge clk);
      end
      if (tx !== 1'b0) begin
         waited = -1;
         return;
      end
      s[0] = tx;
      for (int i = 1; i < FRAME_CYC; i++) begin
         @(negedge clk);
         s[i] = tx;
      end
      framing_ok = 1'b1;
      timing_ok = 1'b1;
      for (int b = 0; b < 5; b++) begin
         if (s[(10 * b) * CLK_DIV + 2] !== 1'b0) framing_ok = 1'b0;
         if (s[(10 * b + 9) * CLK_DIV + 2] !== 1'b1) framing_ok = 1'b0;
         for (int k = 0; k < 8; k++) frame[32 - 8 * b + k] = s[(10 * b + 1 + k) * CLK_DIV + 2];
      end
      for (int i = 1; i < FRAME_CYC; i++) begin
         if (s[i] !== s[i - 1] && (i % CLK_DIV) != 0) timing_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [39:0] f;
      logic fo, to;
      int w, n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      recv_frame(0, f, fo, to, w);
      checks++;
      if (w !== 0) begin failures++; $display("FAIL init_latency: got %0d expected 0", w); end
      checks++;
      if (f !== 40'hA5_00_00_00_00) begin failures++; $display("FAIL init_frame: got %h expected a500000000", f); end
      checks++;
      if (fo !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL init_framing: got %b%b expected 11", fo, to); end
      n = 0;
      while (busy !== 1'b0 && n < 20) begin n++; @(negedge clk); end
      repeat (2) @(negedge clk);
      checks++;
      if (last_busy_len !== 208) begin failures++; $display("FAIL init_busy_len: got %0d expected 208", last_busy_len); end
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL init_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
      $display("test_reset done: frame=%h busy_len=%0d", f, last_busy_len);
   endtask

   task automatic test_change_and_collapse;
      logic [39:0] f;
      logic fo, to;
      int w;
      repeat (5) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL quiet_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
      level1 = 8'h3C;
      fork
         recv_frame(0, f, fo, to, w);
         begin
            repeat (45) @(negedge clk);
            level0 = 8'h10;
            repeat (3) @(negedge clk);
            level0 = 8'h11;
            level2 = 8'hFF;
         end
      join
      checks++;
      if (w !== 0) begin failures++; $display("FAIL change_latency: got %0d expected 0", w); end
      checks++;
      if (f !== 40'hA5_00_3C_00_3C) begin failures++; $display("FAIL change_frame: got %h expected a5003c003c", f); end
      checks++;
      if (fo !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL change_framing: got %b%b expected 11", fo, to); end
      $display("frame 1: %h", f);
      recv_frame(20, f, fo, to, w);
      checks++;
      if (w !== 9) begin failures++; $display("FAIL followup_latency: got %0d expected 9", w); end
      checks++;
      if (f !== 40'hA5_11_3C_FF_D2) begin failures++; $display("FAIL followup_frame: got %h expected a5113cffd2", f); end
      checks++;
      if (fo !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL followup_framing: got %b%b expected 11", fo, to); end
      $display("frame 2: %h wait=%0d", f, w);
   endtask

   task automatic test_revert;
      logic [39:0] f;
      logic fo, to;
      int w, n, lows, fs;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin n++; @(negedge clk); end
      fs = frames_started;
      repeat (50) @(negedge clk);
      checks++;
      if (frames_started !== fs || tx !== 1'b1) begin failures++; $display("FAIL single_followup: got frames=%0d tx=%b expected frames=%0d tx=1", frames_started, tx, fs); end
      level2 = 8'h00;
      fork
         recv_frame(0, f, fo, to, w);
         begin
            repeat (60) @(negedge clk);
            level2 = 8'h55;
            repeat (10) @(negedge clk);
            level2 = 8'h00;
         end
      join
      checks++;
      if (w !== 0 || f !== 40'hA5_11_3C_00_2D) begin failures++; $display("FAIL revert_frame: got %h wait=%0d expected a5113c002d wait=0", f, w); end
      checks++;
      if (fo !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL revert_framing: got %b%b expected 11", fo, to); end
      fs = frames_started;
      lows = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      checks++;
      if (lows !== 0) begin failures++; $display("FAIL revert_quiet_tx: got %0d low cycles expected 0", lows); end
      checks++;
      if (frames_started !== fs || busy !== 1'b0) begin failures++; $display("FAIL revert_no_frame: got frames=%0d busy=%b expected frames=%0d busy=0", frames_started, busy, fs); end
      $display("frame 3: %h quiet_lows=%0d", f, lows);
   endtask

   task automatic test_reset_mid;
      logic [39:0] f;
      logic fo, to;
      int w, n;
      level0 = 8'h80;
      n = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < 5) begin n++; @(negedge clk); end
      checks++;
      if (tx !== 1'b0) begin failures++; $display("FAIL midreset_start: got %b expected 0", tx); end
      repeat (97) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b expected 1", tx); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      recv_frame(0, f, fo, to, w);
      checks++;
      if (w !== 0) begin failures++; $display("FAIL postreset_latency: got %0d expected 0", w); end
      checks++;
      if (f !== 40'hA5_80_3C_00_BC) begin failures++; $display("FAIL postreset_frame: got %h expected a5803c00bc", f); end
      checks++;
      if (fo !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL postreset_framing: got %b%b expected 11", fo, to); end
      $display("frame 4 (after reset): %h", f);
   endtask

   task automatic test_bit_timing;
      logic [39:0] f;
      logic fo, to;
      int w, n;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin n++; @(negedge clk); end
      level1 = 8'h00;
      recv_frame(0, f, fo, to, w);
      checks++;
      if (w !== 0 || f !== 40'hA5_80_00_00_80) begin failures++; $display("FAIL timing_frame: got %h wait=%0d expected a580000080 wait=0", f, w); end
      checks++;
      if (to !== 1'b1) begin failures++; $display("FAIL timing_edges: got %b expected 1", to); end
      checks++;
      if (fo !== 1'b1) begin failures++; $display("FAIL timing_stop_bits: got %b expected 1", fo); end
      n = 0;
      while (busy !== 1'b0 && n < 20) begin n++; @(negedge clk); end
      repeat (2) @(negedge clk);
      checks++;
      if (last_busy_len !== 208 || tx !== 1'b1) begin failures++; $display("FAIL timing_busy_len: got %0d tx=%b expected 208 tx=1", last_busy_len, tx); end
      $display("frame 5: %h busy_len=%0d", f, last_busy_len);
   endtask

   initial begin
      test_reset();
      test_change_and_collapse();
      test_revert();
      test_reset_mid();
      test_bit_timing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
